// File: rtl/level_controller.sv
// Purpose  : game-progress controller; counts hits/misses, tracks score and lives,
//            and drives curr_level into the downstream clock divider.
// Latency  : one cycle; every output is a register updated at the sampling edge.
// Backpress: none; hit/miss/start are single-cycle pulses and are dropped during LVL.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   start      pulse, begins a game from IDLE or OVER
//   hit        pulse, one per point scored
//   miss       pulse, one per life lost
//   curr_level current level (0 in IDLE after reset, 1..MAX_LEVEL in play)
//   score      saturating hit count
//   lives      remaining lives
//   level_up   one-cycle pulse on each level advance
//   game_over  high while in OVER
//
// Optional feature: define LEVEL_BONUS_LIFE_EN to grant one life (saturating at 3)
// on every level advance.

module level_controller #(
    parameter int unsigned HITS_PER_LEVEL = 8,
    parameter int unsigned MAX_LEVEL      = 9,
    parameter int unsigned START_LIVES    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic [3:0] curr_level,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       level_up,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_LVL  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [7:0] LAST_HIT   = 8'(HITS_PER_LEVEL - 1);
    localparam logic [3:0] TOP_LEVEL  = 4'(MAX_LEVEL);
    localparam logic [1:0] INIT_LIVES = 2'(START_LIVES);

    state_t     state, state_nxt;
    logic [7:0] hit_cnt, hit_cnt_nxt;
    logic [3:0] curr_level_nxt;
    logic [7:0] score_nxt;
    logic [1:0] lives_nxt;
    logic       level_up_nxt;
    logic       game_over_nxt;

    logic level_wrap;
    logic last_life;

    assign level_wrap = (hit_cnt == LAST_HIT);
    assign last_life  = (lives == 2'd1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            hit_cnt    <= 8'd0;
            curr_level <= 4'd0;
            score      <= 8'd0;
            lives      <= INIT_LIVES;
            level_up   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            hit_cnt    <= hit_cnt_nxt;
            curr_level <= curr_level_nxt;
            score      <= score_nxt;
            lives      <= lives_nxt;
            level_up   <= level_up_nxt;
            game_over  <= game_over_nxt;
        end
    end

    // Next-state logic. Losing the last life outranks a level advance.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (miss && last_life)
                    state_nxt = ST_OVER;
                else if (hit && level_wrap && (curr_level < TOP_LEVEL))
                    state_nxt = ST_LVL;
            end
            ST_LVL:  state_nxt = ST_PLAY;
            ST_OVER: if (start) state_nxt = ST_PLAY;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and the hit counter.
    always_comb begin
        hit_cnt_nxt    = hit_cnt;
        curr_level_nxt = curr_level;
        score_nxt      = score;
        lives_nxt      = lives;
        level_up_nxt   = 1'b0;
        game_over_nxt  = (state_nxt == ST_OVER);
        case (state)
            ST_IDLE, ST_OVER: begin
                // A start load wins over any hit/miss in the same cycle.
                if (start) begin
                    hit_cnt_nxt    = 8'd0;
                    curr_level_nxt = 4'd1;
                    score_nxt      = 8'd0;
                    lives_nxt      = INIT_LIVES;
                end
            end
            ST_PLAY: begin
                if (hit) begin
                    if (score != 8'hFF)
                        score_nxt = score + 8'd1;
                    hit_cnt_nxt = level_wrap ? 8'd0 : hit_cnt + 8'd1;
                end
                if (miss)
                    lives_nxt = lives - 2'd1;
                if (state_nxt == ST_LVL) begin
                    curr_level_nxt = curr_level + 4'd1;
                    level_up_nxt   = 1'b1;
`ifdef LEVEL_BONUS_LIFE_EN
                    // The bonus life cancels a miss taken on the same edge.
                    if (miss)
                        lives_nxt = lives;
                    else if (lives != 2'd3)
                        lives_nxt = lives + 2'd1;
`endif
                end
            end
            default: ; // LVL: inputs are dropped, only the pulse clears
        endcase
    end

endmodule

// File: tb/tb_level_controller.sv
module tb_level_controller;

    localparam int HPL  = 8;
    localparam int MAXL = 9;
    localparam int SL   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic [3:0] curr_level;
    logic [7:0] score;
    logic [1:0] lives;
    logic       level_up;
    logic       game_over;

    int n_cmp = 0;
    int n_bad = 0;

    level_controller #(
        .HITS_PER_LEVEL(HPL),
        .MAX_LEVEL     (MAXL),
        .START_LIVES   (SL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hit       (hit),
        .miss      (miss),
        .curr_level(curr_level),
        .score     (score),
        .lives     (lives),
        .level_up  (level_up),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    // Behavioural reference: game described as playing / level-pause / over flags
    // with integer counters, stepped once per clock edge.
    int m_level, m_score, m_lives, m_hits;
    bit m_lvlup, m_over, m_playing, m_pause;

    task automatic model_step(input bit r, input bit s, input bit h, input bit ms);
        bit advance;
        advance = 1'b0;
        if (!r) begin
            m_level = 0; m_score = 0; m_lives = SL; m_hits = 0;
            m_lvlup = 0; m_over = 0; m_playing = 0; m_pause = 0;
            return;
        end
        if (m_pause) begin
            // The level pause swallows every input and resumes play.
            m_pause = 0; m_lvlup = 0; m_playing = 1;
            return;
        end
        m_lvlup = 0;
        if (!m_playing) begin
            if (s) begin
                m_level = 1; m_score = 0; m_lives = SL; m_hits = 0;
                m_playing = 1; m_over = 0;
            end
            return;
        end
        if (h) begin
            m_score = (m_score >= 255) ? 255 : m_score + 1;
            m_hits++;
            if (m_hits == HPL) begin
                m_hits = 0;
                advance = (m_level < MAXL);
            end
        end
        if (ms) begin
            m_lives--;
            if (m_lives == 0) begin
                m_over = 1; m_playing = 0; advance = 0;
            end
        end
        if (advance) begin
            m_level++; m_lvlup = 1; m_pause = 1; m_playing = 0;
`ifdef LEVEL_BONUS_LIFE_EN
            if (ms) m_lives = m_lives + 1;
            else if (m_lives < 3) m_lives = m_lives + 1;
`endif
        end
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare #1 later.
    task automatic cycle(input bit r, input bit s, input bit h, input bit ms);
        rst = r; start = s; hit = h; miss = ms;
        @(posedge clk);
        model_step(r, s, h, ms);
        #1;
        check_eq("curr_level", int'(curr_level), m_level);
        check_eq("score",      int'(score),      m_score);
        check_eq("lives",      int'(lives),      m_lives);
        check_eq("level_up",   int'(level_up),   int'(m_lvlup));
        check_eq("game_over",  int'(game_over),  int'(m_over));
    endtask

    // n hits, inserting an idle cycle whenever a level pause is in progress.
    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1, 0, 1, 0);
            if (m_pause) cycle(1, 0, 0, 0);
        end
    endtask

    int lvlup_seen;

    initial begin
        m_level = 0; m_score = 0; m_lives = SL; m_hits = 0;
        m_lvlup = 0; m_over = 0; m_playing = 0; m_pause = 0;

        // Reset then start.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 1);
        check_eq("rst_level", int'(curr_level), 0);
        check_eq("rst_lives", int'(lives), SL);
        cycle(1, 1, 0, 0);
        check_eq("start_level", int'(curr_level), 1);
        check_eq("start_score", int'(score), 0);

        // First level advance: level_up exactly one cycle.
        hits(7);
        cycle(1, 0, 1, 0);
        check_eq("adv_level", int'(curr_level), 2);
        check_eq("adv_pulse", int'(level_up), 1);
        cycle(1, 0, 1, 0);   // hit during pause is dropped
        check_eq("adv_pulse_end", int'(level_up), 0);
        check_eq("adv_score", int'(score), 8);

        // Climb to max level, then 8 more hits without advancing.
        hits(64);
        check_eq("max_level", int'(curr_level), MAXL);
        lvlup_seen = 0;
        for (int i = 0; i < HPL; i++) begin
            cycle(1, 0, 1, 0);
            lvlup_seen += int'(level_up);
        end
        check_eq("max_hold", int'(curr_level), MAXL);
        check_eq("max_no_pulse", lvlup_seen, 0);
        check_eq("max_score", int'(score), 80);

        // Last life lost on the level-completing hit: over wins.
        cycle(1, 1, 0, 0);        // start ignored in play
        cycle(0, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        hits(HPL - 1);
        cycle(1, 0, 1, 1);
        check_eq("go_flag", int'(game_over), 1);
        check_eq("go_level", int'(curr_level), 1);
        check_eq("go_score", int'(score), HPL);
        check_eq("go_pulse", int'(level_up), 0);
        check_eq("go_lives", int'(lives), 0);
        cycle(1, 0, 1, 1);        // ignored in over

        // Score saturation, game over by misses, restart.
        cycle(1, 1, 1, 0);        // start wins over hit
        hits(260);
        check_eq("sat_score", int'(score), 255);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check_eq("sat_over", int'(game_over), 1);
        cycle(1, 1, 0, 0);
        check_eq("restart_score", int'(score), 0);
        check_eq("restart_level", int'(curr_level), 1);
        check_eq("restart_over", int'(game_over), 0);

        // Reset during the level pause.
        cycle(1, 0, 0, 1);
        hits(HPL - 1);
        cycle(1, 0, 1, 0);
`ifdef LEVEL_BONUS_LIFE_EN
        check_eq("bonus_lives", int'(lives), 3);
`else
        check_eq("no_bonus_lives", int'(lives), 2);
`endif
        cycle(0, 0, 1, 0);
        check_eq("lvl_rst_level", int'(curr_level), 0);
        check_eq("lvl_rst_pulse", int'(level_up), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(63) != 0),
                  ($urandom_range(15) == 0),
                  ($urandom_range(1) == 1),
                  ($urandom_range(11) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
